jt12_kon_gen: RTL and testbench
===============================

// Module: jt12_kon_gen
// PURPOSE
//  Parametrised key-on state store for the FM operator pipeline; successor to the fixed 3/6-ch key-on shifter.
//  Holds one key-on bit per (channel, operator) slot; CPU key-on writes update all ops of a channel at once.
//  Presents the key state of the slot being processed ({next_op,next_ch}) to the envelope generator, one cycle later.
//  Adds: any channel count, configurable CSM channel/enable, key-on/key-off edge strobes per slot.
// PARAMETERS
//  NUM_CH  6  channels held (1..8); keyon_ch/next_ch >= NUM_CH are out of range
//  CSM_EN  1  1: CSM forced key-on implemented; 0: csm/overflow_A ignored
//  CSM_CH  2  channel receiving CSM forced key-on (< NUM_CH)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  clk_en      in   1  clock enable; all state advances only when high
//  keyon_op    in   4  key bits from register write, [0]=S1 [1]=S2 [2]=S3 [3]=S4
//  keyon_ch    in   3  channel written by key-on register
//  up_keyon    in   1  key-on register write strobe (one clk_en cycle)
//  next_op     in   2  slot op in pipeline order: 0=S1 1=S3 2=S2 3=S4
//  next_ch     in   3  slot channel
//  csm         in   1  CSM mode select
//  overflow_A  in   1  timer A overflow pulse
//  keyon_I     out  1  key state of the slot (incl. CSM force), registered
//  kon_rise    out  1  slot key went 0->1 since its previous visit, registered
//  kon_fall    out  1  slot key went 1->0 since its previous visit, registered
// BEHAVIOUR
//  Reset: kon[][] =0, prev[][] =0, csm_pend=0, csm_act=0, keyon_I=kon_rise=kon_fall=0.
//  All updates below occur only on clk rising edge with clk_en=1; clk_en=0 holds everything.
//  Write: up_keyon & keyon_ch<NUM_CH -> kon[keyon_ch][3:0] <= keyon_op; out-of-range ch ignored.
//  Op map: next_op 0->bit0, 1->bit2, 2->bit1, 3->bit3.
//  Slot read: k = (next_ch<NUM_CH) ? kon[next_ch][map(next_op)] : 0; f = CSM force (below).
//   keyon_I <= k | f;  kon_rise <= (k|f) & ~prev;  kon_fall <= ~(k|f) & prev;  prev[slot] <= k|f.
//   Out-of-range slot: all three outputs <= 0, no prev update.
//  Write/read collision (up_keyon and keyon_ch==next_ch same cycle): read uses NEW keyon_op bit
//   (write-through), so latency from write to keyon_I is exactly 1 clk_en cycle for the current slot.
//  CSM (CSM_EN=1) states: IDLE -> PEND -> ACT -> IDLE.
//   IDLE: csm & overflow_A -> PEND.
//   PEND: next_ch==CSM_CH & next_op==0 -> ACT (that slot is already forced: f=1).
//   ACT : f=1 for every slot with next_ch==CSM_CH; leave to IDLE after slot (CSM_CH, op 3) served.
//   overflow_A during PEND/ACT: ignored (no re-arm, no extension). csm falling: state -> IDLE next cycle.
//   Forced key appears in prev, so CSM pass produces kon_rise on each op, then kon_fall on next visit.
//  CSM_EN=0: f=0 always, state stays IDLE.
//  No reset mid-operation recovery beyond async reset: rst at any time returns all state to reset values.
// TESTING
//  1) Reset, up_keyon ch=1 op=4'b1111, sweep all slots -> keyon_I=1 & kon_rise=1 only on 4 ch1 slots, 1 cycle later.
//  2) Then keyon_op=4'b0000 ch=1, sweep -> kon_fall=1 on 4 ch1 slots; second sweep: all outputs 0.
//  3) keyon_op=4'b0100 ch=0, slot (ch0,next_op=1) -> keyon_I=1; (ch0,next_op=2) -> 0 (op map check).
//  4) Collision: up_keyon ch=3 op=1111 same cycle as slot (3,0) -> keyon_I=1 next cycle.
//  5) csm=1, overflow_A pulse, kon all 0 -> ch2 four slots keyon_I=1 one pass, next pass 0; second overflow mid-ACT ignored.
//  6) NUM_CH=3, CSM_EN=0: keyon_ch=5 write ignored; overflow_A with csm=1 -> no forced key; rst mid-sweep -> outputs 0 immediately.

Source files
------------

// File: rtl/jt12_kon_gen.sv
// jt12_kon_gen -- key-on state store for the FM operator pipeline.
//
// Holds one key-on bit per (channel, operator) slot. A CPU key-on register
// write replaces all four operator bits of one channel at once. Each clk_en
// cycle the pipeline presents a slot ({next_op,next_ch}). One cycle later the
// block reports that slot's key state and any key edge seen since the slot's
// previous visit. An optional CSM sequencer can force key-on for one full pass
// of a chosen channel after a timer A overflow.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   clk_en          clock enable; all state holds while low
//   keyon_op[3:0]   key bits from register write ([0]=S1 [1]=S2 [2]=S3 [3]=S4)
//   keyon_ch[2:0]   channel addressed by the key-on write
//   up_keyon        key-on register write strobe
//   next_op[1:0]    slot operator in pipeline order (0=S1 1=S3 2=S2 3=S4)
//   next_ch[2:0]    slot channel
//   csm             CSM mode select
//   overflow_A      timer A overflow pulse
//   keyon_I         registered key state of the slot, including the CSM force
//   kon_rise        registered 0->1 key edge for the slot
//   kon_fall        registered 1->0 key edge for the slot

module jt12_kon_gen #(
   parameter int NUM_CH = 6,
   parameter int CSM_EN = 1,
   parameter int CSM_CH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic [3:0] keyon_op,
   input  logic [2:0] keyon_ch,
   input  logic       up_keyon,
   input  logic [1:0] next_op,
   input  logic [2:0] next_ch,
   input  logic       csm,
   input  logic       overflow_A,
   output logic       keyon_I,
   output logic       kon_rise,
   output logic       kon_fall
);

   localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);
   localparam logic [2:0] CSM_CH_W = 3'(CSM_CH);
   localparam bit         CSM_ON   = (CSM_EN != 0);

   typedef enum logic [1:0] {
      CSM_IDLE = 2'd0,
      CSM_PEND = 2'd1,
      CSM_ACT  = 2'd2
   } csm_state_t;

   // Pipeline operator order (S1,S3,S2,S4) to register bit order (S1,S2,S3,S4).
   function automatic logic [1:0] op_to_bit(input logic [1:0] op);
      logic [1:0] b;
      case (op)
         2'd0:    b = 2'd0;
         2'd1:    b = 2'd2;
         2'd2:    b = 2'd1;
         default: b = 2'd3;
      endcase
      return b;
   endfunction

   // Arrays are sized for the full 3-bit channel address so every index is
   // legal; rows at or above NUM_CH are never written and stay zero.
   logic [3:0] kon_r  [8];
   logic [3:0] prev_r [8];

   csm_state_t csm_state_r;
   csm_state_t csm_state_s;

   logic       wr_ok_s;
   logic       slot_ok_s;
   logic       csm_slot_s;
   logic [1:0] bit_s;
   logic       kon_bit_s;
   logic       prev_bit_s;
   logic       force_s;
   logic       key_s;

   // Slot decode, write-through key lookup and final key value.
   always_comb begin
      wr_ok_s    = up_keyon & ({1'b0, keyon_ch} < NUM_CH_W);
      slot_ok_s  = ({1'b0, next_ch} < NUM_CH_W);
      csm_slot_s = slot_ok_s & (next_ch == CSM_CH_W);
      bit_s      = op_to_bit(next_op);
      prev_bit_s = prev_r[next_ch][bit_s];
      // A write to the slot's own channel in the same cycle is seen at once,
      // keeping write-to-keyon_I latency at one cycle.
      if (wr_ok_s && (keyon_ch == next_ch)) begin
         kon_bit_s = keyon_op[bit_s];
      end else if (slot_ok_s) begin
         kon_bit_s = kon_r[next_ch][bit_s];
      end else begin
         kon_bit_s = 1'b0;
      end
      key_s = slot_ok_s & (kon_bit_s | force_s);
   end

   // CSM sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csm_state_r <= CSM_IDLE;
      end else if (clk_en) begin
         csm_state_r <= csm_state_s;
      end
   end

   // CSM next state: arm on overflow, start at the CSM channel's first slot,
   // finish after its S4 slot. Further overflows while busy are ignored.
   always_comb begin
      csm_state_s = csm_state_r;
      case (csm_state_r)
         CSM_IDLE: begin
            if (CSM_ON && csm && overflow_A) begin
               csm_state_s = CSM_PEND;
            end else begin
               csm_state_s = CSM_IDLE;
            end
         end
         CSM_PEND: begin
            if (!csm) begin
               csm_state_s = CSM_IDLE;
            end else if (csm_slot_s && (next_op == 2'd0)) begin
               csm_state_s = CSM_ACT;
            end else begin
               csm_state_s = CSM_PEND;
            end
         end
         CSM_ACT: begin
            if (!csm) begin
               csm_state_s = CSM_IDLE;
            end else if (csm_slot_s && (next_op == 2'd3)) begin
               csm_state_s = CSM_IDLE;
            end else begin
               csm_state_s = CSM_ACT;
            end
         end
         default: begin
            csm_state_s = CSM_IDLE;
         end
      endcase
   end

   // CSM force output: the slot that moves PEND to ACT is already forced.
   always_comb begin
      force_s = 1'b0;
      case (csm_state_r)
         CSM_IDLE: force_s = 1'b0;
         CSM_PEND: force_s = csm & csm_slot_s & (next_op == 2'd0);
         CSM_ACT:  force_s = csm & csm_slot_s;
         default:  force_s = 1'b0;
      endcase
   end

   // Key store, per-slot previous key and registered slot outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            kon_r[i]  <= 4'b0000;
            prev_r[i] <= 4'b0000;
         end
         keyon_I  <= 1'b0;
         kon_rise <= 1'b0;
         kon_fall <= 1'b0;
      end else if (clk_en) begin
         if (wr_ok_s) begin
            kon_r[keyon_ch] <= keyon_op;
         end
         if (slot_ok_s) begin
            keyon_I                <= key_s;
            kon_rise               <= key_s & ~prev_bit_s;
            kon_fall               <= ~key_s & prev_bit_s;
            prev_r[next_ch][bit_s] <= key_s;
         end else begin
            keyon_I  <= 1'b0;
            kon_rise <= 1'b0;
            kon_fall <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jt12_kon_gen.sv
// tb_jt12_kon_gen -- directed bench for jt12_kon_gen.
// dut  : default build (6 channels, CSM on channel 2).
// dut2 : 3 channels, CSM disabled; shares every input with dut.
// Outputs are compared as {keyon_I,kon_rise,kon_fall} one cycle after the slot.

module tb_jt12_kon_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic [3:0] keyon_op = 4'b0000;
   logic [2:0] keyon_ch = 3'd0;
   logic       up_keyon = 1'b0;
   logic [1:0] next_op = 2'd0;
   logic [2:0] next_ch = 3'd7;
   logic       csm = 1'b0;
   logic       overflow_A = 1'b0;

   logic       keyon_I, kon_rise, kon_fall;
   logic       keyon_I2, kon_rise2, kon_fall2;

   int total = 0;
   int bad   = 0;

   jt12_kon_gen dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .keyon_op(keyon_op), .keyon_ch(keyon_ch), .up_keyon(up_keyon),
      .next_op(next_op), .next_ch(next_ch),
      .csm(csm), .overflow_A(overflow_A),
      .keyon_I(keyon_I), .kon_rise(kon_rise), .kon_fall(kon_fall)
   );

   jt12_kon_gen #(.NUM_CH(3), .CSM_EN(0), .CSM_CH(2)) dut2 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .keyon_op(keyon_op), .keyon_ch(keyon_ch), .up_keyon(up_keyon),
      .next_op(next_op), .next_ch(next_ch),
      .csm(csm), .overflow_A(overflow_A),
      .keyon_I(keyon_I2), .kon_rise(kon_rise2), .kon_fall(kon_fall2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Register write while the pipeline points at an unused slot.
   task automatic do_write(input logic [2:0] ch, input logic [3:0] op);
      up_keyon = 1'b1;
      keyon_ch = ch;
      keyon_op = op;
      next_ch  = 3'd7;
      next_op  = 2'd0;
      tick();
      up_keyon = 1'b0;
   endtask

   task automatic visit(input logic [2:0] ch, input logic [1:0] op);
      next_ch = ch;
      next_op = op;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b000) begin
         bad++;
         $display("FAIL reset_dut: got %b want 000", {keyon_I, kon_rise, kon_fall});
      end
      total++;
      if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b000) begin
         bad++;
         $display("FAIL reset_dut2: got %b want 000", {keyon_I2, kon_rise2, kon_fall2});
      end
      @(negedge clk);
      rst = 1'b0;
      visit(3'd7, 2'd0);
   endtask

   task automatic test_keyon_sweep();
      logic [2:0] exp;
      do_write(3'd1, 4'b1111);
      for (int c = 0; c < 6; c++) begin
         for (int o = 0; o < 4; o++) begin
            visit(3'(c), 2'(o));
            exp = (c == 1) ? 3'b110 : 3'b000;
            total++;
            if ({keyon_I, kon_rise, kon_fall} !== exp) begin
               bad++;
               $display("FAIL keyon_sweep ch%0d op%0d: got %b want %b", c, o,
                        {keyon_I, kon_rise, kon_fall}, exp);
            end
         end
      end
   endtask

   task automatic test_keyoff_sweep();
      logic [2:0] exp;
      do_write(3'd1, 4'b0000);
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 0; c < 6; c++) begin
            for (int o = 0; o < 4; o++) begin
               visit(3'(c), 2'(o));
               exp = (pass == 0 && c == 1) ? 3'b001 : 3'b000;
               total++;
               if ({keyon_I, kon_rise, kon_fall} !== exp) begin
                  bad++;
                  $display("FAIL keyoff_sweep p%0d ch%0d op%0d: got %b want %b", pass, c, o,
                           {keyon_I, kon_rise, kon_fall}, exp);
               end
            end
         end
      end
   endtask

   task automatic test_op_map();
      logic [2:0] exp [4];
      // keyon_op bit2 is S3, which the pipeline visits as next_op=1.
      exp[0] = 3'b000;
      exp[1] = 3'b110;
      exp[2] = 3'b000;
      exp[3] = 3'b000;
      do_write(3'd0, 4'b0100);
      for (int o = 0; o < 4; o++) begin
         visit(3'd0, 2'(o));
         total++;
         if ({keyon_I, kon_rise, kon_fall} !== exp[o]) begin
            bad++;
            $display("FAIL op_map op%0d: got %b want %b", o,
                     {keyon_I, kon_rise, kon_fall}, exp[o]);
         end
      end
   endtask

   task automatic test_collision();
      up_keyon = 1'b1;
      keyon_ch = 3'd3;
      keyon_op = 4'b1111;
      next_ch  = 3'd3;
      next_op  = 2'd0;
      tick();
      up_keyon = 1'b0;
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b110) begin
         bad++;
         $display("FAIL collision: got %b want 110", {keyon_I, kon_rise, kon_fall});
      end
      visit(3'd3, 2'd2);
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b110) begin
         bad++;
         $display("FAIL collision_stored: got %b want 110", {keyon_I, kon_rise, kon_fall});
      end
   endtask

   task automatic test_clk_en();
      // With clk_en low the (0,0) slot must not be processed: outputs hold.
      clk_en = 1'b0;
      visit(3'd0, 2'd0);
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b110) begin
         bad++;
         $display("FAIL clk_en_hold: got %b want 110", {keyon_I, kon_rise, kon_fall});
      end
      clk_en = 1'b1;
      visit(3'd3, 2'd1);
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b110) begin
         bad++;
         $display("FAIL clk_en_resume: got %b want 110", {keyon_I, kon_rise, kon_fall});
      end
   endtask

   task automatic test_csm();
      logic [2:0] exp;
      csm        = 1'b1;
      overflow_A = 1'b1;
      visit(3'd7, 2'd0);
      overflow_A = 1'b0;
      // Pending, but the pass only starts at the channel's op 0 slot.
      visit(3'd2, 2'd1);
      total++;
      if ({keyon_I, kon_rise, kon_fall} !== 3'b000) begin
         bad++;
         $display("FAIL csm_pend_wait: got %b want 000", {keyon_I, kon_rise, kon_fall});
      end
      for (int pass = 0; pass < 3; pass++) begin
         for (int o = 0; o < 4; o++) begin
            overflow_A = (pass == 0 && o == 1) ? 1'b1 : 1'b0;
            visit(3'd2, 2'(o));
            overflow_A = 1'b0;
            exp = (pass == 0) ? 3'b110 : ((pass == 1) ? 3'b001 : 3'b000);
            total++;
            if ({keyon_I, kon_rise, kon_fall} !== exp) begin
               bad++;
               $display("FAIL csm_pass p%0d op%0d: got %b want %b", pass, o,
                        {keyon_I, kon_rise, kon_fall}, exp);
            end
         end
      end
      csm = 1'b0;
   endtask

   task automatic test_small_nocsm();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      visit(3'd7, 2'd0);
      do_write(3'd5, 4'b1111);
      csm        = 1'b1;
      overflow_A = 1'b1;
      visit(3'd7, 2'd0);
      overflow_A = 1'b0;
      for (int c = 0; c < 8; c++) begin
         for (int o = 0; o < 4; o++) begin
            visit(3'(c), 2'(o));
            total++;
            if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b000) begin
               bad++;
               $display("FAIL small_sweep ch%0d op%0d: got %b want 000", c, o,
                        {keyon_I2, kon_rise2, kon_fall2});
            end
         end
      end
      csm = 1'b0;
      do_write(3'd2, 4'b1111);
      for (int o = 0; o < 3; o++) begin
         visit(3'd2, 2'(o));
         total++;
         if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b110) begin
            bad++;
            $display("FAIL small_write op%0d: got %b want 110", o,
                     {keyon_I2, kon_rise2, kon_fall2});
         end
      end
      // Asynchronous reset mid-sweep clears the outputs without a clock edge.
      rst = 1'b1;
      #2;
      total++;
      if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b000) begin
         bad++;
         $display("FAIL small_async_rst: got %b want 000", {keyon_I2, kon_rise2, kon_fall2});
      end
      rst = 1'b0;
      visit(3'd2, 2'd3);
      total++;
      if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b000) begin
         bad++;
         $display("FAIL small_after_rst op3: got %b want 000", {keyon_I2, kon_rise2, kon_fall2});
      end
      visit(3'd2, 2'd0);
      total++;
      if ({keyon_I2, kon_rise2, kon_fall2} !== 3'b000) begin
         bad++;
         $display("FAIL small_after_rst op0: got %b want 000", {keyon_I2, kon_rise2, kon_fall2});
      end
   endtask

   initial begin
      test_reset();
      test_keyon_sweep();
      test_keyoff_sweep();
      test_op_map();
      test_collision();
      test_clk_en();
      test_csm();
      test_small_nocsm();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
